// File: rtl/w5300_socket_pkg.sv
// Shared constants for the W5300 socket-n register model.
package w5300_socket_pkg;

    // Register offsets relative to the socket base address.
    localparam logic [5:0] OffMr     = 6'h00;
    localparam logic [5:0] OffCr     = 6'h02;
    localparam logic [5:0] OffImr    = 6'h04;
    localparam logic [5:0] OffIr     = 6'h06;
    localparam logic [5:0] OffSsr    = 6'h08;
    localparam logic [5:0] OffPortr  = 6'h0A;
    localparam logic [5:0] OffDportr = 6'h12;
    localparam logic [5:0] OffDipr0  = 6'h14;
    localparam logic [5:0] OffDipr1  = 6'h16;
    localparam logic [5:0] OffMssr   = 6'h18;
    localparam logic [5:0] OffWrsr0  = 6'h20;
    localparam logic [5:0] OffWrsr1  = 6'h22;
    localparam logic [5:0] OffFsr0   = 6'h24;
    localparam logic [5:0] OffFsr1   = 6'h26;
    localparam logic [5:0] OffRsr0   = 6'h28;
    localparam logic [5:0] OffRsr1   = 6'h2A;
    localparam logic [5:0] OffTxFifo = 6'h2E;
    localparam logic [5:0] OffRxFifo = 6'h30;

    // Command codes written to CR.
    localparam logic [15:0] CmdOpen  = 16'h0001;
    localparam logic [15:0] CmdClose = 16'h0010;
    localparam logic [15:0] CmdSend  = 16'h0020;
    localparam logic [15:0] CmdRecv  = 16'h0040;

    // Socket status codes and the MR protocol value that opens UDP.
    localparam logic [15:0] SsrClosed = 16'h0000;
    localparam logic [15:0] SsrUdp    = 16'h0022;
    localparam logic [3:0]  MrUdp     = 4'h2;

    // Interrupt bits in IR.
    localparam logic [15:0] IrSendOk = 16'h0100;
    localparam logic [15:0] IrRecv   = 16'h0040;

    typedef enum logic {StIdle, StExec} cmd_state_e;

    // Lower-offset word of a split 17-bit value carries only bit 16.
    function automatic logic [15:0] split_hi(input logic [16:0] v);
        return {15'd0, v[16]};
    endfunction

endpackage

// File: rtl/w5300_sync_fifo.sv
// Synchronous FIFO with head-of-queue read data and a flush input.
module w5300_sync_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [Width-1:0]         rdata,
    output logic [$clog2(Depth):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned Aw = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wptr_q, rptr_q;
    logic [Aw:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (Aw+1)'(Depth));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    // Pointers and occupancy; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (Aw+1)'(do_push) - (Aw+1)'(do_pop);
        end
    end

endmodule

// File: rtl/w5300_socket_n_responder.sv
// Behavioural register model of one W5300 socket: register file, command FSM, Tx/Rx sizing.
module w5300_socket_n_responder
    import w5300_socket_pkg::*;
#(
    parameter logic [3:0]  N       = 4'd0,
    parameter int unsigned CMD_LAT = 4,
    parameter logic [16:0] TX_FULL = 17'h02000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [26:0] req_data,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    input  logic        rx_push,
    input  logic [15:0] rx_word,
    output logic        tx_word_valid,
    output logic [15:0] tx_word,
    output logic        send_done,
    output logic        int_n,
    output logic        err_ovf
);
    localparam logic [9:0] Base  = 10'h200 + {N, 6'h00};
    localparam logic [3:0] LatM1 = 4'(CMD_LAT - 1);

    cmd_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mr_q, mr_d, cr_q, cr_d, imr_q, imr_d, ir_q, ir_d, ssr_q, ssr_d;
    logic [15:0] portr_q, portr_d, dportr_q, dportr_d, mssr_q, mssr_d;
    logic [15:0] dipr0_q, dipr0_d, dipr1_q, dipr1_d;
    logic [16:0] wrsr_q, wrsr_d, fsr_q, fsr_d;
    logic        err_q, err_d, txv_q, txv_d, send_q, send_d, rspv_q, rspv_d;
    logic [15:0] txw_q, txw_d, rspd_q, rspd_d;
    logic [15:0] ir_set, ir_clr, rdata;

    logic        req_op, hit, acc, wr, rd;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic [5:0]  off;
    logic        push, pop, flush, fifo_full, fifo_empty;
    logic [15:0] fifo_head;
    logic [4:0]  fifo_count;
    logic [16:0] rsr;

    assign req_op    = req_data[26];
    assign req_addr  = req_data[25:16];
    assign req_wdata = req_data[15:0];
    assign off       = req_addr[5:0];
    assign hit       = (req_addr[9:6] == Base[9:6]);
    assign req_ready = (state_q == StIdle);
    assign acc       = req_valid & req_ready;
    assign wr        = acc & ~req_op & hit;
    assign rd        = acc & req_op;
    assign rsr       = {11'd0, fifo_count, 1'b0};

    w5300_sync_fifo #(
        .Width(16),
        .Depth(16)
    ) u_rx_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(rx_word),
        .pop  (pop),
        .flush(flush),
        .rdata(fifo_head),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Read mux, command FSM, register writes and Rx injection.
    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;    mr_d = mr_q;     cr_d = cr_q;
        imr_d = imr_q;      ssr_d = ssr_q;    portr_d = portr_q; dportr_d = dportr_q;
        dipr0_d = dipr0_q;  dipr1_d = dipr1_q; mssr_d = mssr_q; wrsr_d = wrsr_q;
        fsr_d = fsr_q;      err_d = err_q;    txv_d = 1'b0;    txw_d = txw_q;
        send_d = 1'b0;      rspv_d = rd;      rspd_d = rspd_q;
        ir_set = '0;        ir_clr = '0;      push = 1'b0;     flush = 1'b0;
        rdata = '0;

        if (hit) begin
            case (off)
                OffMr:     rdata = mr_q;
                OffCr:     rdata = cr_q;
                OffImr:    rdata = imr_q;
                OffIr:     rdata = ir_q;
                OffSsr:    rdata = ssr_q;
                OffPortr:  rdata = portr_q;
                OffDportr: rdata = dportr_q;
                OffDipr0:  rdata = dipr0_q;
                OffDipr1:  rdata = dipr1_q;
                OffMssr:   rdata = mssr_q;
                OffWrsr0:  rdata = split_hi(wrsr_q);
                OffWrsr1:  rdata = wrsr_q[15:0];
                OffFsr0:   rdata = split_hi(fsr_q);
                OffFsr1:   rdata = fsr_q[15:0];
                OffRsr0:   rdata = split_hi(rsr);
                OffRsr1:   rdata = rsr[15:0];
                OffRxFifo: rdata = fifo_empty ? 16'h0000 : fifo_head;
                default:   rdata = '0;
            endcase
        end
        if (rd) rspd_d = rdata;
        pop = rd & hit & (off == OffRxFifo) & ~fifo_empty;

        unique case (state_q)
            StIdle: begin
                if (wr && off == OffCr) begin
                    cr_d    = req_wdata;
                    cnt_d   = LatM1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    cr_d    = '0;
                    case (cr_q)
                        CmdOpen:  ssr_d = (mr_q[3:0] == MrUdp) ? SsrUdp : SsrClosed;
                        CmdClose: begin
                            ssr_d = SsrClosed;
                            flush = 1'b1;
                        end
                        CmdSend: begin
                            if (ssr_q == SsrUdp) begin
                                fsr_d  = TX_FULL;
                                wrsr_d = '0;
                                ir_set = ir_set | IrSendOk;
                                send_d = 1'b1;
                            end
                        end
                        CmdRecv: ;
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // CR writes are handled by the FSM above.
        if (wr) begin
            case (off)
                OffMr:     mr_d = req_wdata;
                OffImr:    imr_d = req_wdata;
                OffIr:     ir_clr = req_wdata;
                OffPortr:  portr_d = req_wdata;
                OffDportr: dportr_d = req_wdata;
                OffDipr0:  dipr0_d = req_wdata;
                OffDipr1:  dipr1_d = req_wdata;
                OffMssr:   mssr_d = req_wdata;
                OffWrsr0:  wrsr_d[16] = req_wdata[0];
                OffWrsr1:  wrsr_d[15:0] = req_wdata;
                OffTxFifo: begin
                    if (ssr_q == SsrUdp) begin
                        if (fsr_q >= 17'd2) begin
                            fsr_d = fsr_q - 17'd2;
                            txv_d = 1'b1;
                            txw_d = req_wdata;
                        end else if (fsr_q == '0) begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // A CLOSE flush in the same cycle discards the injected word.
        if (rx_push && !flush && ssr_q == SsrUdp) begin
            if (!fifo_full || pop) begin
                push   = 1'b1;
                ir_set = ir_set | IrRecv;
            end else begin
                err_d = 1'b1;
            end
        end

        // Set events win over a simultaneous write-1-to-clear.
        ir_d = (ir_q & ~ir_clr) | ir_set;
    end

    // State register with synchronous reset; reset aborts any pending command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle; cnt_q <= '0;    mr_q <= '0;     cr_q <= '0;
            imr_q <= '0;       ir_q <= '0;     ssr_q <= '0;    portr_q <= '0;
            dportr_q <= '0;    dipr0_q <= '0;  dipr1_q <= '0;  mssr_q <= '0;
            wrsr_q <= '0;      fsr_q <= TX_FULL; err_q <= 1'b0; txv_q <= 1'b0;
            txw_q <= '0;       send_q <= 1'b0; rspv_q <= 1'b0; rspd_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d;   mr_q <= mr_d;     cr_q <= cr_d;
            imr_q <= imr_d;     ir_q <= ir_d;     ssr_q <= ssr_d;   portr_q <= portr_d;
            dportr_q <= dportr_d; dipr0_q <= dipr0_d; dipr1_q <= dipr1_d; mssr_q <= mssr_d;
            wrsr_q <= wrsr_d;   fsr_q <= fsr_d;   err_q <= err_d;   txv_q <= txv_d;
            txw_q <= txw_d;     send_q <= send_d; rspv_q <= rspv_d; rspd_q <= rspd_d;
        end
    end

    assign rsp_valid     = rspv_q;
    assign rsp_data      = rspd_q;
    assign tx_word_valid = txv_q;
    assign tx_word       = txw_q;
    assign send_done     = send_q;
    assign err_ovf       = err_q;
    assign int_n         = ~|(ir_q & imr_q);

endmodule

// File: tb/tb_w5300_socket_n_responder.sv
// Randomised scoreboard bench for the socket-n responder, socket 1 instance.
module tb_w5300_socket_n_responder;
    localparam logic [3:0] NS   = 4'd1;
    localparam int         LAT  = 4;
    localparam int         TXF  = 'h2000;
    localparam int         BASE = 'h200 + 'h40 * 1;

    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rx_push = 1'b0;
    logic [26:0] req_data = '0;
    logic [15:0] rx_word = '0;
    logic        req_ready, rsp_valid, tx_word_valid, send_done, int_n, err_ovf;
    logic [15:0] rsp_data, tx_word;

    w5300_socket_n_responder #(
        .N(NS),
        .CMD_LAT(LAT),
        .TX_FULL(17'(TXF))
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rx_push(rx_push), .rx_word(rx_word), .tx_word_valid(tx_word_valid),
        .tx_word(tx_word), .send_done(send_done), .int_n(int_n), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, send_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [15:0] data; int cyc;} rsp_t;
    rsp_t        rsp_q[$];
    logic [15:0] tx_q[$];

    // Reference model: socket state as plain variables and a queue for the Rx FIFO.
    logic [15:0] m_mr, m_imr, m_ir, m_ssr, m_portr, m_dport, m_dip0, m_dip1, m_mssr;
    int          m_wrsr, m_fsr, m_send = 0;
    logic [15:0] m_rx[$];
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mr = 0; m_imr = 0; m_ir = 0; m_ssr = 0; m_portr = 0; m_dport = 0;
        m_dip0 = 0; m_dip1 = 0; m_mssr = 0; m_wrsr = 0; m_fsr = TXF; m_err = 0;
        m_rx.delete();
    endtask

    task automatic m_cmd(input logic [15:0] c);
        if (c == 16'h0001) m_ssr = (m_mr[3:0] == 4'h2) ? 16'h0022 : 16'h0000;
        else if (c == 16'h0010) begin m_ssr = 0; m_rx.delete(); end
        else if (c == 16'h0020 && m_ssr == 16'h0022) begin
            m_fsr = TXF; m_wrsr = 0; m_ir = m_ir | 16'h0100; m_send++;
        end
    endtask

    task automatic m_push(input logic [15:0] w);
        if (m_ssr == 16'h0022) begin
            if (m_rx.size() < 16) begin m_rx.push_back(w); m_ir = m_ir | 16'h0040; end
            else m_err = 1;
        end
    endtask

    task automatic m_access(input bit op, input logic [9:0] addr, input logic [15:0] wd,
                            output logic [15:0] rv);
        int o;
        o = int'(addr) - BASE;
        rv = 0;
        if (o < 0 || o > 63) return;
        if (op) begin
            case (o)
                'h00: rv = m_mr;   'h04: rv = m_imr;  'h06: rv = m_ir;  'h08: rv = m_ssr;
                'h0A: rv = m_portr; 'h12: rv = m_dport; 'h14: rv = m_dip0; 'h16: rv = m_dip1;
                'h18: rv = m_mssr;
                'h20: rv = 16'(m_wrsr >> 16); 'h22: rv = 16'(m_wrsr);
                'h24: rv = 16'(m_fsr >> 16);  'h26: rv = 16'(m_fsr);
                'h28: rv = 16'((2 * m_rx.size()) >> 16); 'h2A: rv = 16'(2 * m_rx.size());
                'h30: if (m_rx.size() > 0) rv = m_rx.pop_front();
                default: rv = 0;
            endcase
        end else begin
            case (o)
                'h00: m_mr = wd;   'h02: m_cmd(wd); 'h04: m_imr = wd; 'h06: m_ir = m_ir & ~wd;
                'h0A: m_portr = wd; 'h12: m_dport = wd; 'h14: m_dip0 = wd; 'h16: m_dip1 = wd;
                'h18: m_mssr = wd;
                'h20: m_wrsr = (m_wrsr & 'hFFFF) | (int'(wd[0]) << 16);
                'h22: m_wrsr = (m_wrsr & 'h10000) | int'(wd);
                'h2E: if (m_ssr == 16'h0022) begin
                    if (m_fsr >= 2) begin m_fsr -= 2; tx_q.push_back(wd); end
                    else if (m_fsr == 0) m_err = 1;
                end
                default: ;
            endcase
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or Tx echo.
    always @(negedge clk) begin
        rsp_t        e;
        logic [15:0] t;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_unexpected: got %0h expected no response", rsp_data);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_latency", cyc, e.cyc);
            end
        end
        if (tx_word_valid) begin
            if (tx_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL tx_unexpected: got %0h expected no tx word", tx_word);
            end else begin
                t = tx_q.pop_front();
                chk("tx_word", tx_word, t);
            end
        end
        if (send_done) send_seen++;
    end

    // Issue one request at a falling edge; optional simultaneous rx_push.
    task automatic do_req(input bit op, input logic [9:0] addr, input logic [15:0] wd,
                          input bit with_push, input logic [15:0] pw);
        logic [15:0] rv;
        rsp_t        e;
        int          t, low;
        t = 0;
        while (req_ready !== 1'b1 && t < 64) begin @(negedge clk); t++; end
        if (req_ready !== 1'b1) begin chk("ready_timeout", req_ready, 1); return; end
        req_valid = 1'b1; req_data = {op, addr, wd}; rx_push = with_push; rx_word = pw;
        m_access(op, addr, wd, rv);
        if (op) begin e.data = rv; e.cyc = cyc + 1; rsp_q.push_back(e); end
        if (with_push) m_push(pw);
        @(negedge clk);
        req_valid = 1'b0; rx_push = 1'b0;
        if (!op && int'(addr) == BASE + 2) begin
            low = 0;
            while (req_ready === 1'b0 && low < 40) begin low++; @(negedge clk); end
            chk("cmd_busy_cycles", low, LAT);
        end
    endtask

    task automatic wr(input int o, input logic [15:0] d); do_req(0, 10'(BASE + o), d, 0, 0); endtask
    task automatic rd(input int o); do_req(1, 10'(BASE + o), 0, 0, 0); endtask

    task automatic do_push(input logic [15:0] w);
        rx_push = 1'b1; rx_word = w; m_push(w);
        @(negedge clk);
        rx_push = 1'b0;
    endtask

    task automatic check_state(input string name);
        @(negedge clk);
        chk({name, "_err_ovf"}, err_ovf, m_err);
        chk({name, "_int_n"}, int_n, ((m_ir & m_imr) != 0) ? 1'b0 : 1'b1);
        chk({name, "_send_done_count"}, send_seen, m_send);
    endtask

    task automatic do_reset();
        rst = 1'b1; @(negedge clk); rst = 1'b0; m_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int offs[18] = '{'h00, 'h02, 'h04, 'h06, 'h08, 'h0A, 'h12, 'h14, 'h16, 'h18,
                     'h20, 'h22, 'h24, 'h26, 'h28, 'h2A, 'h2E, 'h30};
    int cmds[5] = '{'h01, 'h10, 'h20, 'h40, 'h07};

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);   chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);     chk("rst_tx_valid", tx_word_valid, 0);
        chk("rst_tx_word", tx_word, 0);       chk("rst_send_done", send_done, 0);
        chk("rst_int_n", int_n, 1);           chk("rst_err_ovf", err_ovf, 0);
        rst = 1'b0;

        // Open UDP and read status back.
        wr('h00, 16'h0002); wr('h02, 16'h0001); rd('h02); rd('h08);
        check_state("open");

        // Own-socket versus other-socket PORTR.
        do_req(0, 10'h24A, 16'h1B58, 0, 0); do_req(1, 10'h24A, 0, 0, 0);
        do_req(1, 10'h20A, 0, 0, 0);

        // Tx FIFO writes, then SEND with SENDOK unmasked.
        for (int i = 0; i < 3; i++) wr('h2E, 16'($urandom));
        rd('h24); rd('h26);
        wr('h04, 16'h0100); wr('h02, 16'h0020);
        rd('h26); rd('h06);
        check_state("send");
        wr('h06, 16'hFFFF);

        // Rx overflow, then drain past empty.
        for (int i = 0; i < 17; i++) do_push(16'($urandom));
        check_state("rx_ovf");
        rd('h28); rd('h2A);
        for (int i = 0; i < 17; i++) rd('h30);

        // OPEN with non-UDP mode keeps the socket closed; Tx is dropped silently.
        do_reset();
        wr('h00, 16'h0001); wr('h02, 16'h0001); rd('h08);
        wr('h2E, 16'hBEEF);
        check_state("closed_tx");

        // Full FIFO: simultaneous pop and push both succeed.
        wr('h00, 16'h0002); wr('h02, 16'h0001);
        for (int i = 0; i < 16; i++) do_push(16'($urandom));
        do_req(1, 10'(BASE + 'h30), 0, 1, 16'($urandom));
        rd('h2A);
        check_state("full_pop_push");

        // IR clear racing a RECV set leaves RECV set.
        rd('h30);
        do_req(0, 10'(BASE + 'h06), 16'h0040, 1, 16'h1234);
        rd('h06);

        // Reset during SEND execution: no completion pulse, FSR back to full.
        do_reset();
        wr('h00, 16'h0002); wr('h02, 16'h0001);
        wr('h2E, 16'h0A0A); wr('h2E, 16'h0B0B);
        req_valid = 1'b1; req_data = {1'b0, 10'(BASE + 2), 16'h0020};
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); chk("ready_during_reset", req_ready, 1);
        rst = 1'b0; m_reset();
        @(negedge clk); chk("ready_after_reset", req_ready, 1);
        repeat (8) @(negedge clk);
        check_state("rst_in_exec");
        rd('h24); rd('h26);

        // Exhaust Tx free size, then one more write overflows.
        wr('h00, 16'h0002); wr('h02, 16'h0001);
        for (int i = 0; i < TXF / 2 + 1; i++) wr('h2E, 16'($urandom));
        rd('h24); rd('h26);
        check_state("tx_ovf");
        wr('h02, 16'h0020);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int          r, o;
            bit          op, wp;
            logic [9:0]  a;
            logic [15:0] d;
            r = $urandom_range(0, 99);
            if (r < 20) begin
                do_push(16'($urandom));
            end else begin
                o  = offs[$urandom_range(0, 17)];
                a  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'(BASE + o);
                op = 1'($urandom_range(0, 1));
                d  = 16'($urandom);
                if (int'(a) == BASE + 'h02) d = 16'(cmds[$urandom_range(0, 4)]);
                if (int'(a) == BASE && $urandom_range(0, 9) < 7) d = 16'h0002;
                wp = (op || int'(a) != BASE + 'h02) && ($urandom_range(0, 3) == 0);
                do_req(op, a, d, wp, 16'($urandom));
            end
            check_state("rand");
        end

        repeat (4) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("tx_queue_drained", tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w5300_socket_n_responder.md
W5300_SOCKET_N_RESPONDER -- requirements
Module: w5300_socket_n_responder

Interface
REQ-001 SHALL have parameter N [3:0], default 0, selecting socket N; register base = 10'h200 + 10'h040*N.
REQ-002 SHALL have parameter CMD_LAT, default 4, giving command execution cycles (range 1..15).
REQ-003 SHALL have parameter TX_FULL [16:0], default 17'h02000, giving Tx free size after reset or SEND.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request strobe.
REQ-007 req_data  input  27  {op (1 = read, 0 = write), addr[9:0], wdata[15:0]}; same packing as the socket LUT entries.
REQ-008 req_ready  output  1  request may be accepted.
REQ-009 rsp_valid  output  1  read response strobe, single cycle, no backpressure.
REQ-010 rsp_data  output  16  read data.
REQ-011 rx_push  input  1  inject one received word into the Rx model.
REQ-012 rx_word  input  16  injected word.
REQ-013 tx_word_valid / tx_word  output  1 / 16  echo of each accepted Tx FIFO write.
REQ-014 send_done  output  1  one-cycle pulse on SEND completion.
REQ-015 int_n  output  1  active-low interrupt: low while |(Sn_IR & Sn_IMR).
REQ-016 err_ovf  output  1  sticky flag; set on Tx FIFO write with FSR = 0 or rx_push with Rx full.

Function
REQ-017 Request acceptance SHALL occur on req_valid & req_ready.
REQ-018 req_ready SHALL be 0 while the command FSM is in EXEC, else 1.
REQ-019 A read SHALL assert rsp_valid exactly 1 cycle after acceptance. A write SHALL produce no response.
REQ-020 Register map (offset from base):
- 0x00 MR (R/W)
- 0x02 CR (R/W)
- 0x04 IMR (R/W)
- 0x06 IR (read; write-1-to-clear)
- 0x08 SSR (read-only)
- 0x0A PORTR (R/W)
- 0x12 DPORTR (R/W)
- 0x14 / 0x16 DIPR (R/W)
- 0x18 MSSR (R/W)
- 0x20 / 0x22 Tx_WRSR (R/W)
- 0x24 / 0x26 Tx_FSR (read-only)
- 0x28 / 0x2A Rx_RSR (read-only)
- 0x2E Tx_FIFOR (write-only)
- 0x30 Rx_FIFOR (read-only)
REQ-021 Reads of unmapped or other-socket addresses SHALL return 16'h0000 with rsp_valid. Writes to them SHALL be ignored.
REQ-022 Split 17-bit values (FSR, RSR, WRSR) SHALL place bit16 in bit 0 of the lower-offset word and bits 15:0 in the higher-offset word.
REQ-023 Command FSM SHALL have states IDLE -> EXEC -> IDLE. A CR write enters EXEC, and CR reads back the command value for CMD_LAT cycles. On exit, CR = 0 and the effect below is applied:
- OPEN (0x01): SSR = 0x22 if MR[3:0] = 0x2, else SSR stays 0x00.
- CLOSE (0x10): SSR = 0x00, Rx FIFO flushed.
- SEND (0x20): only if SSR = 0x22; FSR = TX_FULL, WRSR = 0, IR |= 0x0100 (SENDOK), send_done pulse.
- RECV (0x40): no state change besides clearing CR.
- Any other value: CR cleared only.
REQ-024 A Tx_FIFOR write with SSR = 0x22 and FSR >= 2 SHALL decrement FSR by 2 and pulse tx_word_valid with wdata in the same cycle.
REQ-025 A Tx_FIFOR write with FSR = 0 SHALL be dropped and SHALL set err_ovf. A write with SSR != 0x22 SHALL be dropped silently.
REQ-026 The Rx FIFO SHALL hold 16 words.
- rx_push when SSR = 0x22 and not full: enqueues rx_word and sets IR |= 0x0040 (RECV).
- rx_push when full: dropped, sets err_ovf.
- rx_push when SSR != 0x22: dropped silently.
REQ-027 Rx_RSR SHALL equal 2 × FIFO occupancy.
REQ-028 An Rx_FIFOR read SHALL pop one word and return it. A read when the FIFO is empty SHALL return 0x0000 and leave state unchanged.
REQ-029 If rx_push and an Rx_FIFOR pop occur in the same cycle on a full FIFO, both SHALL succeed and occupancy SHALL stay 16.
REQ-030 An IR write-1-to-clear in the same cycle as an IR set event SHALL leave the bit set.

Reset
REQ-031 On rst, outputs SHALL be: req_ready = 1, rsp_valid = 0, rsp_data = 0, tx_word_valid = 0, tx_word = 0, send_done = 0, int_n = 1, err_ovf = 0.
REQ-032 On rst, all registers SHALL be 0 except FSR = TX_FULL; the FSM goes to IDLE and the Rx FIFO is emptied. Reset SHALL abort EXEC without applying the pending command.

Structure
REQ-033 Register offsets, command codes, SSR codes and IR bit masks SHALL live in a shared package w5300_socket_pkg.
REQ-034 The Rx FIFO SHALL be one sub-module, w5300_sync_fifo (parameterised width 16, depth 16, same clk/rst).

Verification
REQ-035 Reset, then write MR = 0x0002 and CR = 0x0001 -> req_ready low for 4 cycles; CR reads 0x0000 afterwards; SSR reads 0x0022.
REQ-036 N = 1: write PORTR at 0x24A = 0x1B58, then read 0x24A -> 0x1B58; read 0x20A -> 0x0000.
REQ-037 Open UDP, write 3 Tx_FIFOR words -> FSR2 reads 0x1FFA. Then SEND -> send_done pulse, FSR2 reads 0x2000, IR reads 0x0100, int_n low when IMR = 0x0100.
REQ-038 Open UDP, push 17 words -> err_ovf = 1, RSR2 reads 0x0020. Read Rx_FIFOR 16 times -> words returned in order; a 17th read returns 0x0000.
REQ-039 MR = 0x0001, then OPEN -> SSR stays 0x00. A Tx_FIFOR write is dropped: no tx_word_valid, err_ovf stays 0.
REQ-040 Assert rst during EXEC of SEND -> send_done is never asserted; FSR = TX_FULL; req_ready = 1 in the cycle after reset.
